// File: rtl/serdes_arbiter.sv
// Round-robin arbiter sharing one serdes ingress port between NUM_REQ word sources.
// A grant lasts for one burst: until last, MAX_BURST beats, or a source bubble.
module serdes_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0]            req_last,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [DATA_WIDTH-1:0]         ser_data,
    output logic                          ser_valid,
    input  logic                          ser_ready,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id,
    output logic                          busy,
    output logic [$clog2(MAX_BURST+1)-1:0] beat_cnt
);
    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = $clog2(MAX_BURST+1);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IW-1:0]   grant_q, grant_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            sel_found;
    logic [IW-1:0]   sel_idx;
    logic            beat;

    // Search downward in offset so the smallest offset from rr_ptr wins.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int k = NUM_REQ-1; k >= 0; k--) begin
            int j;
            j = (int'(rr_ptr_q) + k) % NUM_REQ;
            if (req_valid[j]) begin
                sel_found = 1'b1;
                sel_idx   = IW'(j);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        grant_d   = grant_q;
        cnt_d     = cnt_q;
        ser_data  = '0;
        ser_valid = 1'b0;
        req_ready = '0;
        beat      = 1'b0;
        case (state_q)
            IDLE: begin
                if (sel_found) begin
                    grant_d = sel_idx;
                    cnt_d   = '0;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                ser_data           = req_data[grant_q*DATA_WIDTH +: DATA_WIDTH];
                ser_valid          = req_valid[grant_q];
                req_ready[grant_q] = ser_ready;
                beat               = ser_valid & ser_ready;
                // A stalled serdes with valid data holds the grant; only a missing word releases it.
                if (!req_valid[grant_q] ||
                    (beat && (req_last[grant_q] || cnt_q == CW'(MAX_BURST-1)))) begin
                    state_d  = IDLE;
                    cnt_d    = '0;
                    rr_ptr_d = (grant_q == IW'(NUM_REQ-1)) ? '0 : grant_q + 1'b1;
                end else if (beat) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            grant_q  <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            grant_q  <= grant_d;
            cnt_q    <= cnt_d;
        end
    end

    assign grant_id = grant_q;
    assign busy     = (state_q == GRANT);
    assign beat_cnt = cnt_q;

`ifndef SYNTHESIS
    a_ready_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(req_ready));
    a_valid_busy:   assert property (@(posedge clk) disable iff (rst) ser_valid |-> busy);
    a_cnt_range:    assert property (@(posedge clk) disable iff (rst) cnt_q <= CW'(MAX_BURST));
`endif
endmodule

// File: doc/serdes_arbiter.md
Name: serdes_arbiter

Overview:
- Round-robin arbiter that shares one serdes ingress port (16-deep FIFO, valid/ready) between NUM_REQ independent parallel-word sources.
- Grants one requester at a time for a burst. The burst ends on last, at MAX_BURST beats, or on a requester bubble.
- The arbiter drives the serdes parallel input and publishes the current grant ID for downstream tagging/debug.
- It sits directly in front of the serdes/FIFO wrapper in the top level.

Parameters:
- NUM_REQ, 4: number of requesters (2..8).
- DATA_WIDTH, 8: word width; must match the serdes DATA_WIDTH.
- MAX_BURST, 4: maximum beats per grant (1..16).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_data  in  NUM_REQ*DATA_WIDTH  requester words; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- req_valid  in  NUM_REQ  per-requester word valid.
- req_last  in  NUM_REQ  per-requester end-of-burst marker, qualified by req_valid.
- req_ready  out  NUM_REQ  per-requester accept; at most one bit high.
- ser_data  out  DATA_WIDTH  word to serdes parallel_in.
- ser_valid  out  1  to serdes valid_in.
- ser_ready  in  1  from serdes ready_out.
- grant_id  out  $clog2(NUM_REQ)  index of current/last granted requester.
- busy  out  1  high while in GRANT state.
- beat_cnt  out  $clog2(MAX_BURST+1)  beats accepted in current burst.

Behaviour:
- Reset (synchronous, rst=1 at clk edge):
  - state=IDLE, rr_ptr=0, grant_id=0, beat_cnt=0, busy=0.
  - ser_valid=0, req_ready=0, ser_data=0.
  - Reset asserted mid-burst abandons the burst immediately. No partial state is retained.
- Beat definition: ser_valid & ser_ready in GRANT.
- State IDLE:
  - ser_valid=0, req_ready=0.
  - If any req_valid bit is set, select the first set bit searching upward from rr_ptr with wrap modulo NUM_REQ.
  - Register the selection into grant_id, clear beat_cnt, go to GRANT.
  - Arbitration costs exactly 1 cycle: the first beat can occur no earlier than the cycle after req_valid is seen in IDLE.
- State GRANT (busy=1):
  - Outputs are combinational from the granted requester g=grant_id:
    - ser_data = req_data slice g.
    - ser_valid = req_valid[g].
    - req_ready[g] = ser_ready; all other req_ready bits are 0.
  - On each beat, beat_cnt increments.
  - Burst ends on the first of these conditions:
    - a beat with req_last[g]=1;
    - a beat that brings beat_cnt to MAX_BURST;
    - a cycle where req_valid[g]=0 (bubble release). No beat occurs on that cycle.
  - On burst end: rr_ptr = (g+1) mod NUM_REQ, state=IDLE, beat_cnt is cleared next cycle, grant_id holds its value.
  - ser_ready=0 with req_valid[g]=1 (serdes FIFO full): stay in GRANT and hold. This is not a bubble. Data stays stable because the source must hold it.
- Fairness: the requester just served has lowest priority in the next arbitration. With all NUM_REQ requesters continuously valid, each is granted once per NUM_REQ bursts.
- Non-granted requesters' req_valid/req_last are ignored. Their words are never dropped, only stalled.
- req_last on a non-beat cycle has no effect.
- MAX_BURST=1: every beat ends the burst.
- No combinational path exists from req_valid of non-granted requesters to any output.
- Assertions (non-synthesis):
  - $onehot0(req_ready).
  - ser_valid implies busy.
  - beat_cnt <= MAX_BURST.

Test Plan:
1. Reset then single requester: req_valid[2]=1 for 3 words 0xA1,0xA2,0xA3 with last on the third, ser_ready=1 -> grant_id=2 one cycle after valid; ser_data sequence A1,A2,A3 on consecutive cycles; busy drops the cycle after the A3 beat; rr_ptr=3.
2. All 4 requesters continuously valid, never last, MAX_BURST=4, ser_ready=1 -> grant order 0,1,2,3,0, each burst exactly 4 beats, 1 idle cycle between bursts.
3. Backpressure: requester 1 granted, ser_ready=0 for 5 cycles mid-burst -> grant held, ser_data stable, beat_cnt frozen; burst completes after ser_ready returns.
4. Bubble release: requester 0 granted, drops req_valid after 2 beats while requester 3 is valid -> return to IDLE, next grant_id=3, beat_cnt for requester 0 = 2.
5. Reset mid-burst: rst=1 at beat 2 of 4 -> next cycle busy=0, ser_valid=0, req_ready=0, grant_id=0; after release, requester 0 arbitrates first again.
6. Simultaneous last and MAX_BURST on beat 4 -> single burst end, no extra beat, rr_ptr advances by exactly one.
